// File: rtl/id_ex_operand_stage.sv
// ID->EX operand stage: destination select, operand B select, EX/MEM and MEM/WB
// forwarding for rs and rt, registered into the ID/EX pipeline register.
module id_ex_operand_stage #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned IMM_W   = 16,
  parameter int unsigned RA_ADDR = 31
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              stall,
  input  logic              flush,
  input  logic [REG_AW-1:0] in_rs,
  input  logic [REG_AW-1:0] in_rt,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [DATA_W-1:0] in_dr1,
  input  logic [DATA_W-1:0] in_dr2,
  input  logic [IMM_W-1:0]  in_imm,
  input  logic [1:0]        sel_aw,
  input  logic [1:0]        sel_src,
  input  logic              in_reg_write,
  input  logic              exm_we,
  input  logic [REG_AW-1:0] exm_addr,
  input  logic [DATA_W-1:0] exm_data,
  input  logic              mwb_we,
  input  logic [REG_AW-1:0] mwb_addr,
  input  logic [DATA_W-1:0] mwb_data,
  output logic              out_valid,
  output logic [REG_AW-1:0] out_aw,
  output logic [DATA_W-1:0] out_op_a,
  output logic [DATA_W-1:0] out_op_b,
  output logic [DATA_W-1:0] out_store_data,
  output logic              out_reg_write
);

  localparam int unsigned EXT_W = DATA_W - IMM_W;

  logic [DATA_W-1:0] fwd_a;
  logic [DATA_W-1:0] fwd_b;
  logic [DATA_W-1:0] op_b;
  logic [REG_AW-1:0] aw;
  logic              exm_hit_a, mwb_hit_a, exm_hit_b, mwb_hit_b;
  logic              bubble;

  // Forwarding match terms; register 0 is never a forwarding source
  assign exm_hit_a = exm_we && (exm_addr == in_rs) && (in_rs != '0);
  assign mwb_hit_a = mwb_we && (mwb_addr == in_rs) && (in_rs != '0);
  assign exm_hit_b = exm_we && (exm_addr == in_rt) && (in_rt != '0);
  assign mwb_hit_b = mwb_we && (mwb_addr == in_rt) && (in_rt != '0);

  // Operand A: EX/MEM result is newer than MEM/WB, which is newer than the register file
  always_comb begin
    fwd_a = in_dr1;
    if (exm_hit_a)      fwd_a = exm_data;
    else if (mwb_hit_a) fwd_a = mwb_data;
  end

  // Forwarded rt feeds both operand B and store data
  always_comb begin
    fwd_b = in_dr2;
    if (exm_hit_b)      fwd_b = exm_data;
    else if (mwb_hit_b) fwd_b = mwb_data;
  end

  // Operand B source select
  always_comb begin
    op_b = '0;
    case (sel_src)
      2'd0:    op_b = fwd_b;
      2'd1:    op_b = {{EXT_W{in_imm[IMM_W-1]}}, in_imm};
      2'd2:    op_b = DATA_W'(in_imm);
      default: op_b[2*IMM_W-1:IMM_W] = in_imm;
    endcase
  end

  // Destination register select; code 3 aliases rt
  always_comb begin
    aw = in_rt;
    case (sel_aw)
      2'd1:    aw = in_rd;
      2'd2:    aw = REG_AW'(RA_ADDR);
      default: aw = in_rt;
    endcase
  end

  // An invalid decode slot loads the same bubble as a flush
  assign bubble = flush || (!stall && !in_valid);

  // ID/EX pipeline register: flush beats stall, stall beats load
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid      <= 1'b0;
      out_reg_write  <= 1'b0;
      out_aw         <= '0;
      out_op_a       <= '0;
      out_op_b       <= '0;
      out_store_data <= '0;
    end else if (bubble) begin
      out_valid      <= 1'b0;
      out_reg_write  <= 1'b0;
      out_aw         <= '0;
      out_op_a       <= '0;
      out_op_b       <= '0;
      out_store_data <= '0;
    end else if (!stall) begin
      out_valid      <= 1'b1;
      out_reg_write  <= in_reg_write;
      out_aw         <= aw;
      out_op_a       <= fwd_a;
      out_op_b       <= op_b;
      out_store_data <= fwd_b;
    end
  end

endmodule
